mult_booth_n: RTL and testbench

- Parametrised sequential radix-2 Booth multiplier; next generation of the team's 4-bit A/Q/M multiplier with control unit.
- Generalised to N-bit operands, with a run-time signed/unsigned mode and a busy/fin handshake.
- Sits as a datapath slave: a controller pulses start with operands and collects a 2N-bit product when fin rises.

---
 rtl/mult_booth_n_pkg.sv | 27 ++
 rtl/mult_booth_n_if.sv | 27 ++
 rtl/mult_booth_n_booth_step.sv | 38 +++
 rtl/mult_booth_n.sv | 103 ++++++++++
 tb/tb_mult_booth_n.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_booth_n_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
// Latency: n/a (types, constants and an elaboration-time width helper only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, Booth decode patterns for {q0, qm1}, clog2.
package mult_pkg;

   // FSM state encoding (plain constants so older tools and netlists keep the same codes)
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Booth recoding of the multiplier bit pair {Q[0], qm1}
   typedef logic [1:0] booth_pair_t;
   localparam booth_pair_t BOOTH_SUB = 2'b10;   // start of a run of ones: subtract M
   localparam booth_pair_t BOOTH_ADD = 2'b01;   // end of a run of ones: add M

   // Ceiling log2, used for the step counter width at elaboration time
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/mult_booth_n_if.sv
// Controller-to-multiplier bus: operands and mode in, product and status out.
// Latency: n/a (wires only).
// Backpressure: none; the controller must see busy=0 and no fin before pulsing start.
//
// master: controller side (drives start/operands, reads producto/fin/busy)
// slave : multiplier side
interface mult_booth_n_if #(
   parameter int N = 8
);
   logic           start;
   logic           signed_mode;
   logic [N-1:0]   multiplicador;
   logic [N-1:0]   multiplicando;
   logic [2*N-1:0] producto;
   logic           fin;
   logic           busy;

   modport master (
      output start, signed_mode, multiplicador, multiplicando,
      input  producto, fin, busy
   );

   modport slave (
      input  start, signed_mode, multiplicador, multiplicando,
      output producto, fin, busy
   );
endinterface

// File: rtl/mult_booth_n_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then arithmetic shift right.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports: i_a/i_q/i_qm1 current partial state, i_m multiplicand (all W bits except qm1);
//        o_a/o_q/o_qm1 state after the add/sub and the 1-bit shift of {A, Q, qm1}.
module booth_step
   import mult_pkg::*;
#(
   parameter int W = 9
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_q,
   input  logic         i_qm1,
   input  logic [W-1:0] i_m,
   output logic [W-1:0] o_a,
   output logic [W-1:0] o_q,
   output logic         o_qm1
);

   logic [W-1:0] w_sum;

   // Modulo 2^W arithmetic; M is an extended N-bit value so it never overflows A's range.
   always_comb begin
      w_sum = i_a;
      case ({i_q[0], i_qm1})
         BOOTH_SUB: w_sum = i_a - i_m;
         BOOTH_ADD: w_sum = i_a + i_m;
         default:   w_sum = i_a;
      endcase
   end

   // Arithmetic shift of {A', Q, qm1}: A's MSB is replicated, A's LSB enters Q, Q's LSB becomes qm1
   assign o_a   = {w_sum[W-1], w_sum[W-1:1]};
   assign o_q   = {w_sum[0], i_q[W-1:1]};
   assign o_qm1 = i_q[0];

endmodule

// File: rtl/mult_booth_n.sv
// Sequential radix-2 Booth multiplier, N-bit operands, run-time signed/unsigned, 2N-bit product.
// Latency: fin is high in the cycle after the (N+1)th step edge, N+2 cycles start edge to fin edge.
// Backpressure: start is only sampled in IDLE; starts during RUN/DONE are dropped.
//
// Ports: clk, reset (async, active-high); bus (slave modport): start, signed_mode,
//        multiplicador, multiplicando in; producto, fin, busy out.
module mult_booth_n
   import mult_pkg::*;
#(
   parameter int N = 8
) (
   input  logic          clk,
   input  logic          reset,
   mult_booth_n_if.slave bus
);

   // One extra bit lets both unsigned and signed operands live as W-bit two's complement
   localparam int W  = N + 1;
   localparam int CW = clog2(W + 1);

   state_t         r_state;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_q;
   logic [W-1:0]   r_m;
   logic           r_qm1;
   logic [CW-1:0]  r_count;
   logic [2*N-1:0] r_producto;
   logic           r_fin;
   logic           r_busy;

   logic [W-1:0]   w_a_nxt;
   logic [W-1:0]   w_q_nxt;
   logic           w_qm1_nxt;

   function automatic logic [W-1:0] ext(input logic [N-1:0] v, input logic s);
      return {s & v[N-1], v};
   endfunction

   booth_step #(
      .W (W)
   ) u_booth_step (
      .i_a   (r_a),
      .i_q   (r_q),
      .i_qm1 (r_qm1),
      .i_m   (r_m),
      .o_a   (w_a_nxt),
      .o_q   (w_q_nxt),
      .o_qm1 (w_qm1_nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_a        <= '0;
         r_q        <= '0;
         r_m        <= '0;
         r_qm1      <= 1'b0;
         r_count    <= '0;
         r_producto <= '0;
         r_fin      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_fin <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_a     <= '0;
                  r_qm1   <= 1'b0;
                  r_q     <= ext(bus.multiplicador, bus.signed_mode);
                  r_m     <= ext(bus.multiplicando, bus.signed_mode);
                  r_count <= CW'(W);
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_a     <= w_a_nxt;
               r_q     <= w_q_nxt;
               r_qm1   <= w_qm1_nxt;
               r_count <= r_count - CW'(1);
               if (r_count == CW'(1)) begin
                  // Low 2N bits of the shifted {A, Q}: top N-1 bits of A's low part plus all of Q
                  r_producto <= {w_a_nxt[N-2:0], w_q_nxt};
                  r_fin      <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.producto = r_producto;
   assign bus.fin      = r_fin;
   assign bus.busy     = r_busy;

endmodule

// File: tb/tb_mult_booth_n.sv
// Directed bench for mult_booth_n at N = 8 plus N = 4 / N = 16 instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_mult_booth_n;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   mult_booth_n_if #(.N(4))  if4 ();
   mult_booth_n_if #(.N(8))  if8 ();
   mult_booth_n_if #(.N(16)) if16 ();

   mult_booth_n #(.N(4))  u_dut4  (.clk(clk), .reset(reset), .bus(if4));
   mult_booth_n #(.N(8))  u_dut8  (.clk(clk), .reset(reset), .bus(if8));
   mult_booth_n #(.N(16)) u_dut16 (.clk(clk), .reset(reset), .bus(if16));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int w, input logic st, input logic [15:0] a,
                        input logic [15:0] b, input logic sm);
      case (w)
         4: begin
            if4.start = st; if4.signed_mode = sm;
            if4.multiplicador = a[3:0]; if4.multiplicando = b[3:0];
         end
         16: begin
            if16.start = st; if16.signed_mode = sm;
            if16.multiplicador = a; if16.multiplicando = b;
         end
         default: begin
            if8.start = st; if8.signed_mode = sm;
            if8.multiplicador = a[7:0]; if8.multiplicando = b[7:0];
         end
      endcase
   endtask

   function automatic logic rd_fin(input int w);
      case (w)
         4:       return if4.fin;
         16:      return if16.fin;
         default: return if8.fin;
      endcase
   endfunction

   function automatic logic rd_busy(input int w);
      case (w)
         4:       return if4.busy;
         16:      return if16.busy;
         default: return if8.busy;
      endcase
   endfunction

   function automatic logic [31:0] rd_prod(input int w);
      case (w)
         4:       return 32'(if4.producto);
         16:      return if16.producto;
         default: return 32'(if8.producto);
      endcase
   endfunction

   // Reference: plain integer multiply of the interpreted operands, truncated to 2w bits
   function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                           input logic [15:0] b, input logic sm);
      longint ea, eb, p, mask;
      mask = (longint'(1) << w) - 1;
      ea = longint'(a) & mask;
      eb = longint'(b) & mask;
      if (sm && ea[w-1]) ea = ea - (longint'(1) << w);
      if (sm && eb[w-1]) eb = eb - (longint'(1) << w);
      p = ea * eb;
      return 32'(p & ((longint'(1) << (2 * w)) - 1));
   endfunction

   // Issue one operation from IDLE and wait (bounded) for fin. lat = edges from start edge to
   // the edge that samples fin; nbusy = cycles with busy high before fin. At wait cycle chg the
   // operands and mode are scrambled to show they are not resampled.
   task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic sm,
                        input int chg, output logic [31:0] prod, output int lat, output int nbusy);
      int  k;
      bit  done;
      @(negedge clk);
      drive(w, 1'b1, a, b, sm);
      @(posedge clk);
      @(negedge clk);
      drive(w, 1'b0, a, b, sm);
      k = 0; nbusy = 0; done = 0; lat = -1; prod = '0;
      while (!done && k < 60) begin
         if (rd_fin(w)) begin
            done = 1;
            lat  = k + 1;
            prod = rd_prod(w);
         end else begin
            if (rd_busy(w)) nbusy = nbusy + 1;
            if (k == chg) drive(w, 1'b0, ~a, ~b, ~sm);
            @(negedge clk);
            k = k + 1;
         end
      end
      if (!done) check("fin_timeout", 64'd0, 64'd1);
   endtask

   logic [31:0] prod;
   int          lat;
   int          nbusy;
   int          fin_cnt;
   int          last_fin;
   int          bad_gap;
   int          bad_prod;
   logic [15:0] ra;
   logic [15:0] rb;

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      drive(4, 1'b0, 16'd0, 16'd0, 1'b0);
      drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
      drive(16, 1'b0, 16'd0, 16'd0, 1'b0);
      repeat (3) @(negedge clk);
      check("rst_prod", 64'(if8.producto), 64'd0);
      check("rst_fin",  64'(if8.fin),      64'd0);
      check("rst_busy", 64'(if8.busy),     64'd0);
      reset = 1'b0;
      @(negedge clk);

      // 7 * -3 signed, with latency and busy duration
      do_op(8, 16'h07, 16'hFD, 1'b1, -1, prod, lat, nbusy);
      check("s_7x-3",      64'(prod),  64'hFFEB);
      check("s_7x-3_lat",  64'(lat),   64'd10);
      check("s_7x-3_busy", 64'(nbusy), 64'd9);
      @(negedge clk);
      check("fin_one_cycle", 64'(if8.fin), 64'd0);
      check("prod_held",     64'(if8.producto), 64'hFFEB);

      do_op(8, 16'h80, 16'h80, 1'b1, -1, prod, lat, nbusy);
      check("s_-128x-128", 64'(prod), 64'h4000);
      do_op(8, 16'h7F, 16'h80, 1'b1, -1, prod, lat, nbusy);
      check("s_127x-128", 64'(prod), 64'hC080);
      do_op(8, 16'hFF, 16'hFF, 1'b0, -1, prod, lat, nbusy);
      check("u_255x255", 64'(prod), 64'hFE01);
      do_op(8, 16'hFF, 16'hFF, 1'b1, -1, prod, lat, nbusy);
      check("s_-1x-1", 64'(prod), 64'h0001);
      do_op(8, 16'h00, 16'hAB, 1'b0, -1, prod, lat, nbusy);
      check("u_zero",     64'(prod), 64'h0000);
      check("u_zero_lat", 64'(lat),  64'd10);
      // 12 * 11 signed, operands and mode scrambled (start low) mid-run
      do_op(8, 16'h0C, 16'h0B, 1'b1, 3, prod, lat, nbusy);
      check("midrun_change", 64'(prod), 64'h0084);

      // start held high: 3 * 5 unsigned, fin every N+3 cycles
      @(negedge clk);
      drive(8, 1'b1, 16'd3, 16'd5, 1'b0);
      fin_cnt = 0; last_fin = -1; bad_gap = 0; bad_prod = 0;
      for (int i = 0; i < 41; i++) begin
         @(negedge clk);
         if (if8.fin) begin
            if (last_fin >= 0 && (i - last_fin) != 11) bad_gap = bad_gap + 1;
            if (if8.producto !== 16'h000F) bad_prod = bad_prod + 1;
            last_fin = i;
            fin_cnt  = fin_cnt + 1;
         end
      end
      drive(8, 1'b0, 16'd3, 16'd5, 1'b0);
      check("held_fin_count", 64'(fin_cnt),  64'd3);
      check("held_fin_gap",   64'(bad_gap),  64'd0);
      check("held_prod",      64'(bad_prod), 64'd0);
      check("held_last_prod", 64'(if8.producto), 64'h000F);
      repeat (15) @(negedge clk);

      // asynchronous reset 4 steps into RUN
      @(negedge clk);
      drive(8, 1'b1, 16'h7F, 16'h7F, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(8, 1'b0, 16'h7F, 16'h7F, 1'b1);
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_prod", 64'(if8.producto), 64'd0);
      check("arst_busy", 64'(if8.busy),     64'd0);
      check("arst_fin",  64'(if8.fin),      64'd0);
      @(negedge clk);
      reset = 1'b0;
      fin_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (if8.fin) fin_cnt = fin_cnt + 1;
      end
      check("arst_no_fin", 64'(fin_cnt), 64'd0);
      do_op(8, 16'h0C, 16'h0C, 1'b0, -1, prod, lat, nbusy);
      check("u_12x12", 64'(prod), 64'h0090);

      // N = 4
      do_op(4, 16'h8, 16'h8, 1'b1, -1, prod, lat, nbusy);
      check("n4_s_-8x-8",  64'(prod),  64'h40);
      check("n4_lat",      64'(lat),   64'd6);
      check("n4_busy",     64'(nbusy), 64'd5);
      do_op(4, 16'hF, 16'hF, 1'b0, -1, prod, lat, nbusy);
      check("n4_u_15x15", 64'(prod), 64'hE1);
      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom_range(0, 15));
         rb = 16'($urandom_range(0, 15));
         do_op(4, ra, rb, i[0], -1, prod, lat, nbusy);
         check("n4_rand",     64'(prod), 64'(ref_mul(4, ra, rb, i[0])));
         check("n4_rand_lat", 64'(lat),  64'd6);
      end

      // N = 16
      do_op(16, 16'hFFFF, 16'hFFFF, 1'b0, -1, prod, lat, nbusy);
      check("n16_u_max",  64'(prod), 64'hFFFE0001);
      check("n16_lat",    64'(lat),  64'd18);
      do_op(16, 16'h8000, 16'h7FFF, 1'b1, -1, prod, lat, nbusy);
      check("n16_s_min_max", 64'(prod), 64'hC0008000);
      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(0, 65535));
         do_op(16, ra, rb, i[0], -1, prod, lat, nbusy);
         check("n16_rand",     64'(prod), 64'(ref_mul(16, ra, rb, i[0])));
         check("n16_rand_lat", 64'(lat),  64'd18);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
